// File: rtl/rot_pkg.sv
// Shared constants and types for the rotation scheduler datapath.
package rot_pkg;

  // Default coordinate and coefficient widths.
  localparam int ROT_W     = 10;
  localparam int ROT_CW    = 12;
  // Coefficients are Q10: 1024 represents 1.0.
  localparam int Q10_SHIFT = 10;

  typedef logic signed [ROT_W-1:0]  point_t;
  typedef logic signed [ROT_CW-1:0] coef_t;

  typedef struct packed {
    point_t x;
    point_t y;
  } xy_t;

  typedef struct packed {
    coef_t c;
    coef_t s;
  } cs_t;

  // Width of a requester index; a single requester still gets one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rot_mac.sv
// Product (S2) and sum/shift (S3) stages of the rotation datapath.
// Both stages advance only when en_i is high, so a downstream stall
// freezes everything in place.
module rot_mac
  import rot_pkg::*;
#(
  parameter int W   = ROT_W,
  parameter int CW  = ROT_CW,
  parameter int IDW = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic                 valid_i,
  input  logic [IDW-1:0]       id_i,
  input  logic signed [W-1:0]  x_i,
  input  logic signed [W-1:0]  y_i,
  input  logic signed [CW-1:0] cos_i,
  input  logic signed [CW-1:0] sin_i,
  output logic                 s2_valid_o,
  output logic                 valid_o,
  output logic [IDW-1:0]       id_o,
  output logic [W-1:0]         x_o,
  output logic [W-1:0]         y_o
);

  // Products are exact in W+CW bits; sums need one more bit.
  localparam int PW = W + CW;
  localparam int SW = PW + 1;

  logic signed [PW-1:0] x_ext, y_ext, cos_ext, sin_ext;
  logic signed [PW-1:0] xc_q, ys_q, yc_q, xs_q;
  logic                 s2_valid_q;
  logic [IDW-1:0]       s2_id_q;
  logic signed [SW-1:0] sx_d, sy_d;
  logic                 s3_valid_q;
  logic [IDW-1:0]       s3_id_q;
  logic [W-1:0]         s3_x_q, s3_y_q;
  logic                 sum_unused;

  // Sign-extend operands to full product width before multiplying.
  assign x_ext   = {{CW{x_i[W-1]}}, x_i};
  assign y_ext   = {{CW{y_i[W-1]}}, y_i};
  assign cos_ext = {{W{cos_i[CW-1]}}, cos_i};
  assign sin_ext = {{W{sin_i[CW-1]}}, sin_i};

  // S2: register the four partial products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      xc_q       <= '0;
      ys_q       <= '0;
      yc_q       <= '0;
      xs_q       <= '0;
    end else if (en_i) begin
      s2_valid_q <= valid_i;
      if (valid_i) begin
        s2_id_q <= id_i;
        xc_q    <= x_ext * cos_ext;
        ys_q    <= y_ext * sin_ext;
        yc_q    <= y_ext * cos_ext;
        xs_q    <= x_ext * sin_ext;
      end
    end
  end

  // Exact sums with one guard bit so extreme coefficients cannot overflow.
  assign sx_d = {xc_q[PW-1], xc_q} + {ys_q[PW-1], ys_q};
  assign sy_d = {yc_q[PW-1], yc_q} - {xs_q[PW-1], xs_q};

  // Fraction bits and bits above the result width are dropped on purpose (wrap).
  assign sum_unused = ^{sx_d[SW-1:W+Q10_SHIFT], sx_d[Q10_SHIFT-1:0],
                        sy_d[SW-1:W+Q10_SHIFT], sy_d[Q10_SHIFT-1:0]};

  // S3: floor-shift by the Q10 scale and register the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid_q <= 1'b0;
      s3_id_q    <= '0;
      s3_x_q     <= '0;
      s3_y_q     <= '0;
    end else if (en_i) begin
      s3_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        s3_id_q <= s2_id_q;
        s3_x_q  <= sx_d[W+Q10_SHIFT-1:Q10_SHIFT];
        s3_y_q  <= sy_d[W+Q10_SHIFT-1:Q10_SHIFT];
      end
    end
  end

  assign s2_valid_o = s2_valid_q;
  assign valid_o    = s3_valid_q;
  assign id_o       = s3_id_q;
  assign x_o        = s3_x_q;
  assign y_o        = s3_y_q;

endmodule

// File: rtl/rot_sched.sv
// Round-robin scheduler sharing one 3-stage rotation pipeline among
// N_REQ requesters. Holds the arbiter and the S1 operand capture.
module rot_sched
  import rot_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = ROT_W,
  parameter int CW    = ROT_CW
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_REQ-1:0]                  req_valid,
  output logic [N_REQ-1:0]                  req_ready,
  input  logic [N_REQ-1:0][W-1:0]           req_x,
  input  logic [N_REQ-1:0][W-1:0]           req_y,
  input  logic [N_REQ-1:0][CW-1:0]          req_sin,
  input  logic [N_REQ-1:0][CW-1:0]          req_cos,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [W-1:0]                      res_x,
  output logic [W-1:0]                      res_y,
  output logic [id_width(N_REQ)-1:0]        res_id,
  output logic                              busy
);

  localparam int IDW = id_width(N_REQ);

  logic [IDW-1:0]   last_grant_q;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   scan_idx;
  logic [N_REQ-1:0] grant;
  logic             grant_any;
  logic             stall;
  logic             accept;

  logic             s1_valid_q;
  logic [IDW-1:0]   s1_id_q;
  logic [W-1:0]     s1_x_q, s1_y_q;
  logic [CW-1:0]    s1_cos_q, s1_sin_q;
  logic             s2_valid;

  // Round-robin search starting one past the last accepted requester.
  always_comb begin
    grant     = '0;
    grant_idx = last_grant_q;
    grant_any = 1'b0;
    scan_idx  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = IDW'((int'(last_grant_q) + k) % N_REQ);
      if (!grant_any && req_valid[scan_idx]) begin
        grant_any       = 1'b1;
        grant[scan_idx] = 1'b1;
        grant_idx       = scan_idx;
      end
    end
  end

  // A result waiting on downstream freezes the whole pipe; nothing is
  // offered while in reset.
  assign stall     = res_valid & ~res_ready;
  assign req_ready = grant & {N_REQ{~stall & rst_n}};
  assign accept    = |req_ready;

  // Pointer moves only on an actual transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= IDW'(N_REQ - 1);
    end else if (accept) begin
      last_grant_q <= grant_idx;
    end
  end

  // S1: capture the winning requester's operands and index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_cos_q   <= '0;
      s1_sin_q   <= '0;
    end else if (!stall) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_id_q  <= grant_idx;
        s1_x_q   <= req_x[grant_idx];
        s1_y_q   <= req_y[grant_idx];
        s1_cos_q <= req_cos[grant_idx];
        s1_sin_q <= req_sin[grant_idx];
      end
    end
  end

  rot_mac #(
    .W   (W),
    .CW  (CW),
    .IDW (IDW)
  ) u_mac (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (~stall),
    .valid_i    (s1_valid_q),
    .id_i       (s1_id_q),
    .x_i        (s1_x_q),
    .y_i        (s1_y_q),
    .cos_i      (s1_cos_q),
    .sin_i      (s1_sin_q),
    .s2_valid_o (s2_valid),
    .valid_o    (res_valid),
    .id_o       (res_id),
    .x_o        (res_x),
    .y_o        (res_y)
  );

  assign busy = s1_valid_q | s2_valid | res_valid;

endmodule

// File: tb/tb_rot_sched.sv
// Directed testbench for rot_sched with hand-computed expectations.
module tb_rot_sched;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [3:0][9:0]  req_x, req_y;
  logic [3:0][11:0] req_sin, req_cos;
  logic             res_valid;
  logic             res_ready;
  logic [9:0]       res_x, res_y;
  logic [1:0]       res_id;
  logic             busy;

  int n_assert = 0;
  int n_fail   = 0;

  rot_sched #(.N_REQ(4), .W(10), .CW(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_sin   (req_sin),
    .req_cos   (req_cos),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_x     (res_x),
    .res_y     (res_y),
    .res_id    (res_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int x, input int y,
                         input int c, input int s);
    req_x[i]   = 10'(x);
    req_y[i]   = 10'(y);
    req_cos[i] = 12'(c);
    req_sin[i] = 12'(s);
  endtask

  // Identity operands: requester i returns x=10*(i+1), y=-(i+1).
  task automatic load_identity();
    for (int i = 0; i < 4; i++) set_req(i, 10 * (i + 1), -(i + 1), 1024, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    res_ready = 1'b1;
    req_valid = 4'hF;
    load_identity();

    // Reset state
    step(); step();
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_x", $signed(res_x), 0);
    chk("rst_res_y", $signed(res_y), 0);
    chk("rst_res_id", res_id, 0);

    // Identity on requester 0, exact 3-cycle latency
    step();
    rst_n     = 1'b1;
    req_valid = 4'b0001;
    set_req(0, 100, -50, 1024, 0);
    #1;
    chk("id_ready", req_ready, 1);
    step();
    req_valid = 4'b0000;
    #1;
    chk("id_lat1_valid", res_valid, 0);
    chk("id_lat1_busy", busy, 1);
    step(); #1;
    chk("id_lat2_valid", res_valid, 0);
    step(); #1;
    chk("id_lat3_valid", res_valid, 1);
    chk("id_res_x", $signed(res_x), 100);
    chk("id_res_y", $signed(res_y), -50);
    chk("id_res_id", res_id, 0);
    step(); #1;
    chk("id_after_valid", res_valid, 0);

    // Rotation on requester 1 (pointer now at 0)
    set_req(1, 100, 0, 1016, 124);
    req_valid = 4'b0010;
    #1;
    chk("rot_ready", req_ready, 2);
    step();
    req_valid = 4'b0000;
    step(); step(); #1;
    chk("rot_valid", res_valid, 1);
    chk("rot_res_x", $signed(res_x), 99);
    chk("rot_res_y", $signed(res_y), -13);
    chk("rot_res_id", res_id, 1);

    // Extremes on requester 2
    step();
    set_req(2, -512, -512, -2048, -2048);
    req_valid = 4'b0100;
    #1;
    chk("ext_ready", req_ready, 4);
    step();
    req_valid = 4'b0000;
    step(); step(); #1;
    chk("ext_valid", res_valid, 1);
    chk("ext_res_x", $signed(res_x), 0);
    chk("ext_res_y", $signed(res_y), 0);
    chk("ext_res_id", res_id, 2);

    // Backpressure: pointer at 2, grants 3,0,1 fill the pipe
    step();
    load_identity();
    req_valid = 4'hF;
    #1; chk("bp_grant_k0", req_ready, 8);
    step(); #1; chk("bp_grant_k1", req_ready, 1);
    step(); #1; chk("bp_grant_k2", req_ready, 2);
    for (int k = 3; k < 8; k++) begin
      step();
      res_ready = 1'b0;
      #1;
      chk("bp_stall_valid", res_valid, 1);
      chk("bp_stall_id", res_id, 3);
      chk("bp_stall_x", $signed(res_x), 40);
      chk("bp_stall_y", $signed(res_y), -4);
      chk("bp_stall_ready", req_ready, 0);
    end
    step();
    res_ready = 1'b1;
    #1;
    chk("bp_release_ready", req_ready, 4);
    chk("bp_release_id", res_id, 3);
    step();
    req_valid = 4'b0000;
    #1;
    chk("bp_out1_valid", res_valid, 1);
    chk("bp_out1_id", res_id, 0);
    chk("bp_out1_x", $signed(res_x), 10);
    step(); #1;
    chk("bp_out2_id", res_id, 1);
    chk("bp_out2_x", $signed(res_x), 20);
    step(); #1;
    chk("bp_out3_id", res_id, 2);
    chk("bp_out3_x", $signed(res_x), 30);
    step(); #1;
    chk("bp_drain_valid", res_valid, 0);

    // Reset mid-stream: pointer at 2, three items enter then reset
    req_valid = 4'hF;
    #1; chk("mr_grant_k0", req_ready, 8);
    step(); #1; chk("mr_grant_k1", req_ready, 1);
    step(); #1; chk("mr_grant_k2", req_ready, 2);
    step(); #1;
    chk("mr_pre_valid", res_valid, 1);
    chk("mr_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_rst_valid", res_valid, 0);
    chk("mr_rst_busy", busy, 0);
    chk("mr_rst_ready", req_ready, 0);
    chk("mr_rst_x", $signed(res_x), 0);
    chk("mr_rst_id", res_id, 0);
    step();
    rst_n = 1'b1;

    // Fairness straight after release: grants 0,1,2,3,0,1
    for (int k = 0; k < 10; k++) begin
      if (k == 6) req_valid = 4'b0000;
      #1;
      if (k < 6) chk("fair_grant", req_ready, 1 << (k % 4));
      else       chk("fair_idle_ready", req_ready, 0);
      if (k < 3 || k == 9) begin
        chk("fair_no_result", res_valid, 0);
      end else begin
        chk("fair_valid", res_valid, 1);
        chk("fair_id", res_id, (k - 3) % 4);
        chk("fair_x", $signed(res_x), 10 * ((k - 3) % 4 + 1));
      end
      step();
    end
    #1;
    chk("end_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rot_sched.md
ROT_SCHED -- requirements
Module: rot_sched

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the rotation datapath.
REQ-002 Parameter W, default 10, signed coordinate width.
REQ-003 Parameter CW, default 12, signed Q10 coefficient width (1024 = 1.0).
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port req_valid  input  N_REQ  per-requester operand valid.
REQ-007 Port req_ready  output  N_REQ  per-requester accept; at most one bit high per cycle.
REQ-008 Port req_x, req_y  input  N_REQ x W  signed point per requester.
REQ-009 Port req_sin, req_cos  input  N_REQ x CW  signed coefficients per requester.
REQ-010 Port res_valid  output  1  result valid.
REQ-011 Port res_ready  input  1  downstream accepts result.
REQ-012 Port res_x, res_y  output  W  signed rotated point.
REQ-013 Port res_id  output  clog2(N_REQ)  index of the requester that owns the result.
REQ-014 Port busy  output  1  high while any pipeline stage holds valid data.

Function
REQ-015 Transfer occurs on req_valid[i] & req_ready[i]; result handoff on res_valid & res_ready.
REQ-016 Arbitration SHALL be round-robin: search starts at last_grant+1 modulo N_REQ; first valid requester wins.
REQ-017 last_grant SHALL update only on an accepted transfer; idle cycles leave it unchanged.
REQ-018 req_ready[i] SHALL be grant[i] & ~stall, where stall = res_valid & ~res_ready.
REQ-019 Pipeline of 3 registered stages: S1 captures operands + id; S2 registers four products x*cos, y*sin, y*cos, x*sin (each W+CW bits); S3 registers sums and output.
REQ-020 Latency: an accepted transfer in cycle n SHALL present res_valid in cycle n+3 when unstalled.
REQ-021 Throughput: one transfer per cycle sustained when res_ready stays high.
REQ-022 Arithmetic: sx = x*cos + y*sin, sy = y*cos - x*sin, exact in W+CW+1 bits; res_x = sx[W+9:10], res_y = sy[W+9:10] (floor shift by 10, upper bits discarded, no saturation).
REQ-023 Stall freezes all stages and last_grant; res_x, res_y, res_id SHALL hold stable while res_valid & ~res_ready.
REQ-024 Empty cycles (no req_valid) SHALL propagate bubbles; res_valid low for the matching cycle.
REQ-025 Requester deasserting req_valid before acceptance SHALL lose the grant without side effects.
REQ-026 Full coefficient range of CW bits, including -2048 and 1024, SHALL be handled without overflow of intermediates.
REQ-027 busy = OR of S1, S2, S3 valid bits.

Reset
REQ-028 rst_n low SHALL immediately clear all stage valid bits; res_valid, req_ready, busy read 0 while in reset.
REQ-029 During reset res_x, res_y, res_id SHALL be 0 and last_grant SHALL be N_REQ-1 (so requester 0 wins first).
REQ-030 Reset asserted mid-operation SHALL discard in-flight results; none SHALL appear after release.

Structure
REQ-031 Shared package rot_pkg holds W, CW, Q10 shift constant (10), and the point/coefficient typedefs.
REQ-032 One sub-module rot_mac: stage S2-S3 product/sum datapath with stall enable, instantiated once.
REQ-033 Arbiter and S1 capture stay in rot_sched.

Verification
REQ-034 Identity: req 0 x=100 y=-50 cos=1024 sin=0 -> res 100,-50, id 0, exactly 3 cycles after accept.
REQ-035 Rotation: x=100 y=0 cos=1016 sin=124 -> res_x=99, res_y=-13.
REQ-036 Fairness: all 4 req_valid held high, res_ready high -> grants 0,1,2,3,0,1 on consecutive cycles, one result per cycle.
REQ-037 Backpressure: res_ready low 5 cycles with full pipe -> res_* stable, req_ready all 0, no loss or duplication after release.
REQ-038 Reset mid-stream: rst_n pulsed low with 3 items in flight -> res_valid 0 immediately, no stale results, first grant to requester 0.
REQ-039 Extremes: x=-512 y=-512 cos=-2048 sin=-2048 -> sx=2097152 -> res_x=0 (wrap), sy=0 -> res_y=0.
